pix_texture_fb_writer: RTL and testbench

Downstream consumer of the per-pixel attribute interpolator. Accepts one 57-bit pixel word {x, y, r, g, b, Tx, Ty}, clips it against the framebuffer bounds, fetches a texel from a synchronous texture RAM, modulates the interpolated colour by the texel, and issues one write to the framebuffer arbiter. It is the last stage of the pixel pipeline before framebuffer memory.

---
 rtl/pix_texture_fb_writer.sv | 134 +++++++++++++
 tb/tb_pix_texture_fb_writer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pix_texture_fb_writer.sv
// pix_texture_fb_writer: clips pixels to the framebuffer, modulates colour by a texel, issues framebuffer writes
// Ports: clk_i / reset_n_i (async, active-low); valid_pix_i, ready_pix_o, pix_data_i {x,y,r,g,b,Tx,Ty} input;
// tex_rd_o, tex_addr_o {Ty,Tx}, tex_data_i texture RAM (one-cycle read latency);
// fb_we_o, fb_ready_i, fb_addr_o, fb_data_o framebuffer write; clip_cnt_o, overflow_o status.
// Define TEX_MODULATE_EN to modulate colour by the texel; otherwise colour passes straight through.
module pix_texture_fb_writer #(
  parameter int FB_W = 320,
  parameter int FB_H = 240
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        valid_pix_i,
  output logic        ready_pix_o,
  input  logic [56:0] pix_data_i,
  output logic        tex_rd_o,
  output logic [15:0] tex_addr_o,
  input  logic [23:0] tex_data_i,
  output logic        fb_we_o,
  input  logic        fb_ready_i,
  output logic [16:0] fb_addr_o,
  output logic [23:0] fb_data_o,
  output logic [15:0] clip_cnt_o,
  output logic        overflow_o
);
  typedef enum logic [1:0] {IDLE, TEX_RD, TEX_WAIT, WRITE} state_t;
`ifdef TEX_MODULATE_EN
  localparam state_t LOADED = TEX_RD;
`else
  localparam state_t LOADED = WRITE;
`endif
  state_t state, state_nxt;
  logic [56:0] fifo_q [2];
  logic wr_ptr, rd_ptr;
  logic [1:0] count;
  logic push, pop, clip, load_rd, load_fb;
  logic [56:0] head;
  logic [16:0] head_addr, fb_addr_nxt;
  logic [23:0] fb_data_nxt;
  assign head = fifo_q[rd_ptr];
  assign clip = 32'(head[56:48]) >= FB_W || 32'(head[47:40]) >= FB_H;
  assign head_addr = 17'(32'(head[47:40]) * FB_W + 32'(head[56:48]));
  assign ready_pix_o = count == 2'd0;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (load_rd) state_nxt = LOADED;
      TEX_RD:   state_nxt = TEX_WAIT;
      TEX_WAIT: state_nxt = WRITE;
      WRITE:    if (fb_ready_i) state_nxt = IDLE;
    endcase
  end
  always_comb begin
    push = valid_pix_i && count != 2'd2;
    pop = state == IDLE && count != 2'd0;
    load_rd = pop && !clip;
`ifdef TEX_MODULATE_EN
    load_fb = state == TEX_WAIT;
`else
    load_fb = load_rd;
`endif
  end
  // A full buffer drops the word even if a pop happens in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      overflow_o <= 1'b0;
      clip_cnt_o <= 16'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
      if (valid_pix_i && !push) overflow_o <= 1'b1;
      if (pop && clip && clip_cnt_o != 16'hFFFF) clip_cnt_o <= clip_cnt_o + 16'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= pix_data_i;
  end
`ifdef TEX_MODULATE_EN
  logic [16:0] pix_addr;
  logic [23:0] pix_rgb;
  // c*(t+1) keeps full-white texels transparent and black texels fully dark.
  function automatic logic [7:0] modulate(input logic [7:0] c, input logic [7:0] t);
    logic [16:0] p;
    p = {9'd0, c} * {9'd0, t} + {9'd0, c};
    return 8'(p >> 8);
  endfunction
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tex_rd_o <= 1'b0;
      tex_addr_o <= 16'd0;
      pix_addr <= 17'd0;
      pix_rgb <= 24'd0;
    end else begin
      tex_rd_o <= load_rd;
      if (load_rd) begin
        tex_addr_o <= {head[7:0], head[15:8]};
        pix_addr <= head_addr;
        pix_rgb <= head[39:16];
      end
    end
  end
  assign fb_addr_nxt = pix_addr;
  assign fb_data_nxt = {modulate(pix_rgb[23:16], tex_data_i[23:16]),
                        modulate(pix_rgb[15:8], tex_data_i[15:8]),
                        modulate(pix_rgb[7:0], tex_data_i[7:0])};
`else
  logic unused_tex;
  assign unused_tex = ^{tex_data_i, head[15:0]};
  assign tex_rd_o = 1'b0;
  assign tex_addr_o = 16'd0;
  assign fb_addr_nxt = head_addr;
  assign fb_data_nxt = head[39:16];
`endif
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fb_we_o <= 1'b0;
      fb_addr_o <= 17'd0;
      fb_data_o <= 24'd0;
    end else begin
      fb_we_o <= load_fb || (fb_we_o && !fb_ready_i);
      if (load_fb) begin
        fb_addr_o <= fb_addr_nxt;
        fb_data_o <= fb_data_nxt;
      end
    end
  end
endmodule

// File: tb/tb_pix_texture_fb_writer.sv
// tb_pix_texture_fb_writer: directed self-checking bench for pix_texture_fb_writer
module tb_pix_texture_fb_writer;
  logic clk = 1'b0, reset_n = 1'b0, valid_pix = 1'b0, fb_ready = 1'b1;
  logic ready_pix, tex_rd, fb_we, overflow;
  logic [56:0] pix_data = '0;
  logic [15:0] tex_addr, clip_cnt;
  logic [23:0] tex_data, tex_word = '0;
  logic [16:0] fb_addr;
  logic [23:0] fb_data;
  int n_cmp = 0, n_bad = 0;
  pix_texture_fb_writer dut (
    .clk_i(clk), .reset_n_i(reset_n), .valid_pix_i(valid_pix), .ready_pix_o(ready_pix),
    .pix_data_i(pix_data), .tex_rd_o(tex_rd), .tex_addr_o(tex_addr), .tex_data_i(tex_data),
    .fb_we_o(fb_we), .fb_ready_i(fb_ready), .fb_addr_o(fb_addr), .fb_data_o(fb_data),
    .clip_cnt_o(clip_cnt), .overflow_o(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tex_data <= tex_rd ? tex_word : 24'hxxxxxx;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [56:0] mk(input int x, input int y, input logic [23:0] rgb, input logic [15:0] txy);
    return {9'(x), 8'(y), rgb, txy};
  endfunction
  function automatic logic [23:0] pick(input logic [23:0] m, input logic [23:0] r);
`ifdef TEX_MODULATE_EN
    return m;
`else
    return r;
`endif
  endfunction
  task automatic send(input logic [56:0] p);
    @(negedge clk);
    valid_pix = 1'b1;
    pix_data = p;
    @(negedge clk);
    valid_pix = 1'b0;
  endtask
  // Entered in the cycle where the word is popped; returns in the first cycle fb_we is high.
  task automatic follow(input string tag, input logic [56:0] p, input logic [23:0] tw,
                        input logic [16:0] ea, input logic [23:0] ed);
    tex_word = tw;
    chk({tag, "_ready_busy"}, ready_pix, 0);
    chk({tag, "_we_early"}, fb_we, 0);
    @(negedge clk);
`ifdef TEX_MODULATE_EN
    chk({tag, "_tex_rd"}, tex_rd, 1);
    chk({tag, "_tex_addr"}, tex_addr, {p[7:0], p[15:8]});
    chk({tag, "_we_n2"}, fb_we, 0);
    @(negedge clk);
    chk({tag, "_tex_rd_pulse"}, tex_rd, 0);
    chk({tag, "_we_n3"}, fb_we, 0);
    @(negedge clk);
`else
    chk({tag, "_tex_rd_tied"}, tex_rd, 0);
    chk({tag, "_tex_addr_tied"}, tex_addr, 0);
`endif
    chk({tag, "_we"}, fb_we, 1);
    chk({tag, "_addr"}, fb_addr, ea);
    chk({tag, "_data"}, fb_data, ed);
  endtask
  task automatic do_pixel(input string tag, input logic [56:0] p, input logic [23:0] tw,
                          input logic [16:0] ea, input logic [23:0] ed);
    send(p);
    follow(tag, p, tw, ea, ed);
    @(negedge clk);
    chk({tag, "_we_done"}, fb_we, 0);
    chk({tag, "_ready_idle"}, ready_pix, 1);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, ready_pix, 1);
    chk({tag, "_tex_rd"}, tex_rd, 0);
    chk({tag, "_tex_addr"}, tex_addr, 0);
    chk({tag, "_we"}, fb_we, 0);
    chk({tag, "_addr"}, fb_addr, 0);
    chk({tag, "_data"}, fb_data, 0);
    chk({tag, "_clip"}, clip_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);
    do_pixel("single", mk(10, 5, 24'hFF8000, 16'h1234), 24'hFFFFFF, 17'd1610, 24'hFF8000);
    do_pixel("mod", mk(3, 2, 24'hC8C8C8, 16'h00AB), 24'h8000FF, 17'd643, pick(24'h6400C8, 24'hC8C8C8));
    send(mk(320, 0, 24'h777777, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      chk("clip_x_tex_rd", tex_rd, 0);
      chk("clip_x_we", fb_we, 0);
      @(negedge clk);
    end
    chk("clip_x_cnt", clip_cnt, 1);
    send(mk(0, 240, 24'h777777, 16'h0000));
    repeat (2) @(negedge clk);
    chk("clip_y_we", fb_we, 0);
    chk("clip_y_cnt", clip_cnt, 2);
    do_pixel("corner", mk(319, 239, 24'h102030, 16'hFFFF), 24'h000000, 17'd76799, pick(24'h000000, 24'h102030));
    fb_ready = 1'b0;
    send(mk(100, 200, 24'h123456, 16'h0102));
    follow("bp_a", mk(100, 200, 24'h123456, 16'h0102), 24'hFF0080, 17'd64100, pick(24'h12002B, 24'h123456));
    send(mk(0, 0, 24'hFFFFFF, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_we", fb_we, 1);
      chk("bp_hold_addr", fb_addr, 64100);
      chk("bp_hold_data", fb_data, pick(24'h12002B, 24'h123456));
      chk("bp_hold_ready", ready_pix, 0);
      @(negedge clk);
    end
    fb_ready = 1'b1;
    chk("bp_last_we", fb_we, 1);
    @(negedge clk);
    follow("bp_b", mk(0, 0, 24'hFFFFFF, 16'h0000), 24'h7F7F7F, 17'd0, pick(24'h7F7F7F, 24'hFFFFFF));
    @(negedge clk);
    chk("bp_done_we", fb_we, 0);
    chk("bp_done_ready", ready_pix, 1);
    fb_ready = 1'b0;
    send(mk(1, 1, 24'h010203, 16'h0000));
    follow("ov_a", mk(1, 1, 24'h010203, 16'h0000), 24'hFFFFFF, 17'd321, 24'h010203);
    chk("ov_none", overflow, 0);
    @(negedge clk);
    valid_pix = 1'b1;
    pix_data = mk(2, 1, 24'hAABBCC, 16'h0000);
    @(negedge clk);
    pix_data = mk(3, 1, 24'h405060, 16'h0000);
    @(negedge clk);
    pix_data = mk(4, 1, 24'hDDDDDD, 16'h0000);
    @(negedge clk);
    valid_pix = 1'b0;
    chk("ov_flag", overflow, 1);
    chk("ov_hold_we", fb_we, 1);
    chk("ov_hold_addr", fb_addr, 321);
    fb_ready = 1'b1;
    @(negedge clk);
    follow("ov_b", mk(2, 1, 24'hAABBCC, 16'h0000), 24'hFFFFFF, 17'd322, 24'hAABBCC);
    @(negedge clk);
    follow("ov_c", mk(3, 1, 24'h405060, 16'h0000), 24'hFFFFFF, 17'd323, 24'h405060);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ov_dropped_we", fb_we, 0);
    end
    chk("ov_sticky", overflow, 1);
    chk("ov_ready", ready_pix, 1);
    fb_ready = 1'b0;
    tex_word = 24'hFFFFFF;
    send(mk(7, 7, 24'h111111, 16'h0505));
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    fb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_we", fb_we, 0);
    chk("midrst_ready", ready_pix, 1);
    do_pixel("after_rst", mk(10, 5, 24'hFF8000, 16'h1234), 24'hFFFFFF, 17'd1610, 24'hFF8000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
